// File: rtl/mux2_arb_if.sv
// rtl/mux2_arb_if.sv - request/grant bundle between two producers and the mux2 select arbiter
interface mux2_arb_if #(
    parameter int HOLD_W = 4
);
    logic              req1;
    logic              req2;
    logic              done;
    logic              gnt1;
    logic              gnt2;
    logic              sel;
    logic [HOLD_W-1:0] hold_cnt;
    logic              preempt;

    modport master (
        input  req1, req2, done,
        output gnt1, gnt2, sel, hold_cnt, preempt
    );

    modport slave (
        output req1, req2, done,
        input  gnt1, gnt2, sel, hold_cnt, preempt
    );
endinterface

// File: rtl/mux2_arb.sv
// rtl/mux2_arb.sv - two-requester round-robin arbiter with bounded tenure driving mux2 sel
module mux2_arb #(
    parameter int HOLD_W   = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    mux2_arb_if.master bus
);
    if (MAX_HOLD < 0 || MAX_HOLD > (1 << HOLD_W) - 1) begin : g_bad_max_hold
        $error("mux2_arb: MAX_HOLD out of range for HOLD_W");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        G1   = 2'd1,
        G2   = 2'd2
    } state_t;

    state_t            state_q, state_d, arb_pick;
    logic              last2_q, last2_d;
    logic              sel_q, sel_d;
    logic              preempt_q, preempt_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              cur_req, oth_req, hit_max, rel, tenure_end;

    always_comb begin
        cur_req = 1'b0;
        oth_req = 1'b0;
        case (state_q)
            G1: begin
                cur_req = bus.req1;
                oth_req = bus.req2;
            end
            G2: begin
                cur_req = bus.req2;
                oth_req = bus.req1;
            end
            default: ;
        endcase

        // Timeout only rotates when there is someone to rotate to.
        hit_max    = (MAX_HOLD != 0) && (hold_q == HOLD_W'(MAX_HOLD - 1)) && oth_req;
        rel        = !cur_req || bus.done;
        tenure_end = (state_q != IDLE) && (rel || hit_max);
        last2_d    = tenure_end ? (state_q == G2) : last2_q;

        if (bus.req1 && bus.req2) begin
            arb_pick = last2_d ? G1 : G2;
        end else if (bus.req1) begin
            arb_pick = G1;
        end else if (bus.req2) begin
            arb_pick = G2;
        end else begin
            arb_pick = IDLE;
        end

        state_d = (state_q == IDLE || tenure_end) ? arb_pick : state_q;

        if (state_d == IDLE || state_q == IDLE || tenure_end) begin
            hold_d = '0;
        end else if (hold_q == '1) begin
            hold_d = hold_q;
        end else begin
            hold_d = hold_q + HOLD_W'(1);
        end

        case (state_d)
            G1:      sel_d = 1'b0;
            G2:      sel_d = 1'b1;
            default: sel_d = sel_q;
        endcase

        preempt_d = tenure_end && !rel;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            last2_q   <= 1'b1;
            sel_q     <= 1'b0;
            hold_q    <= '0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last2_q   <= last2_d;
            sel_q     <= sel_d;
            hold_q    <= hold_d;
            preempt_q <= preempt_d;
        end
    end

    assign bus.gnt1     = (state_q == G1);
    assign bus.gnt2     = (state_q == G2);
    assign bus.sel      = sel_q;
    assign bus.hold_cnt = hold_q;
    assign bus.preempt  = preempt_q;
endmodule

// File: tb/tb_mux2_arb.sv
// tb/tb_mux2_arb.sv - scoreboard bench for mux2_arb with MAX_HOLD=8 and MAX_HOLD=0 instances
module tb_mux2_arb;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mux2_arb_if #(.HOLD_W(4)) ifa ();
    mux2_arb_if #(.HOLD_W(4)) ifb ();

    mux2_arb #(.HOLD_W(4), .MAX_HOLD(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa.master));
    mux2_arb #(.HOLD_W(4), .MAX_HOLD(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb.master));

    typedef struct packed {
        logic       g1;
        logic       g2;
        logic       s;
        logic [3:0] h;
        logic       p;
    } obs_t;

    typedef struct {
        int   owner;
        int   last;
        int   hold;
        logic sel;
        logic pre;
    } mdl_t;

    int   total  = 0;
    int   passed = 0;
    int   stepno = 0;
    obs_t qa[$];
    obs_t qb[$];
    mdl_t ma, mb;

    function automatic mdl_t mstep(mdl_t m, logic rn, logic r1, logic r2, logic d, int maxh);
        mdl_t n;
        bit   ended, by_rel, by_max, mine, other;
        int   w;
        n = m;
        if (!rn) begin
            n.owner = 0; n.last = 2; n.hold = 0; n.sel = 1'b0; n.pre = 1'b0;
            return n;
        end
        n.pre = 1'b0;
        if (m.owner == 0) begin
            ended = 1'b1;
        end else begin
            mine   = (m.owner == 1) ? r1 : r2;
            other  = (m.owner == 1) ? r2 : r1;
            by_rel = !mine || d;
            by_max = (maxh != 0) && (m.hold == maxh - 1) && other;
            ended  = by_rel || by_max;
            if (ended) begin
                n.last = m.owner;
                n.pre  = by_max && !by_rel;
            end
        end
        if (ended) begin
            if (r1 && r2)  w = (n.last == 1) ? 2 : 1;
            else if (r1)   w = 1;
            else if (r2)   w = 2;
            else           w = 0;
            n.owner = w;
            n.hold  = 0;
            if (w == 1) n.sel = 1'b0;
            if (w == 2) n.sel = 1'b1;
        end else begin
            n.hold = (m.hold == 15) ? 15 : m.hold + 1;
        end
        return n;
    endfunction

    function automatic obs_t to_obs(mdl_t m);
        obs_t o;
        o.g1 = (m.owner == 1);
        o.g2 = (m.owner == 2);
        o.s  = m.sel;
        o.h  = 4'(m.hold);
        o.p  = m.pre;
        return o;
    endfunction

    function automatic obs_t get_a();
        return '{ifa.gnt1, ifa.gnt2, ifa.sel, ifa.hold_cnt, ifa.preempt};
    endfunction

    function automatic obs_t get_b();
        return '{ifb.gnt1, ifb.gnt2, ifb.sel, ifb.hold_cnt, ifb.preempt};
    endfunction

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s step %0d observed %h expected %h", tag, stepno, got, exp);
    endtask

    // One clock of stimulus: drive, push model prediction, then pop and compare after the edge.
    task automatic cyc(input logic a1, input logic a2, input logic ad,
                       input logic b1, input logic b2, input logic bd, input logic rn);
        obs_t ea, eb;
        ifa.req1 = a1; ifa.req2 = a2; ifa.done = ad;
        ifb.req1 = b1; ifb.req2 = b2; ifb.done = bd;
        rst_n = rn;
        ma = mstep(ma, rn, a1, a2, ad, 8);
        mb = mstep(mb, rn, b1, b2, bd, 0);
        qa.push_back(to_obs(ma));
        qb.push_back(to_obs(mb));
        @(posedge clk);
        #1;
        stepno++;
        ea = qa.pop_front();
        eb = qb.pop_front();
        chk("sb_a", 8'(get_a()), 8'(ea));
        chk("sb_b", 8'(get_b()), 8'(eb));
    endtask

    task automatic cyc_a(input logic a1, input logic a2, input logic ad);
        cyc(a1, a2, ad, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int npre, bad;
        ma = '{0, 2, 0, 1'b0, 1'b0};
        mb = '{0, 2, 0, 1'b0, 1'b0};
        #1;
        do_reset();
        do_reset();
        chk("reset_state", 8'(get_a()), 8'h00);

        // Single requester, count up, then drop.
        cyc_a(1, 0, 0);
        chk("t1_grant", {5'd0, ifa.gnt1, ifa.gnt2, ifa.sel}, 8'b100);
        chk("t1_hold0", 8'(ifa.hold_cnt), 8'd0);
        cyc_a(1, 0, 0);
        cyc_a(1, 0, 0);
        chk("t1_hold2", 8'(ifa.hold_cnt), 8'd2);
        cyc_a(0, 0, 0);
        chk("t1_drop", {5'd0, ifa.gnt1, ifa.gnt2, ifa.sel}, 8'b000);

        // Simultaneous requests after reset, done-driven handover.
        do_reset();
        cyc_a(1, 1, 0);
        chk("t2_first_g1", {6'd0, ifa.gnt1, ifa.gnt2}, 8'b10);
        cyc_a(1, 1, 1);
        chk("t2_to_g2", {5'd0, ifa.gnt2, ifa.sel, ifa.preempt}, 8'b110);
        cyc_a(1, 1, 1);
        chk("t2_back_g1", {5'd0, ifa.gnt1, ifa.sel, ifa.preempt}, 8'b100);

        // Contention with MAX_HOLD=8: forced rotation every 8 cycles.
        do_reset();
        cyc_a(1, 1, 0);
        npre = 0;
        for (int i = 1; i <= 32; i++) begin
            cyc_a(1, 1, 0);
            if (ifa.preempt) npre++;
            if (i % 8 == 0)
                chk("t3_rotate", {5'd0, ifa.gnt2, ifa.preempt, 1'b0}, {5'd0, 1'((i / 8) % 2), 1'b1, 1'b0});
            else if (i % 8 == 7)
                chk("t3_hold7", 8'(ifa.hold_cnt), 8'd7);
        end
        chk("t3_npre", 8'(npre), 8'd4);

        // Lone requester past MAX_HOLD: no preemption, saturating count.
        do_reset();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc_a(0, 1, 0);
            if (!ifa.gnt2 || ifa.preempt) bad++;
        end
        chk("t4_no_preempt", 8'(bad), 8'd0);
        chk("t4_saturate", 8'(ifa.hold_cnt), 8'd15);

        // Reset mid-tenure.
        do_reset();
        for (int i = 0; i < 6; i++) cyc_a(0, 1, 0);
        chk("t5_g2_h5", {3'd0, ifa.gnt2, ifa.hold_cnt}, 8'h15);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_reset", 8'(get_a()), 8'h00);
        cyc_a(1, 1, 0);
        chk("t5_g1_first", {6'd0, ifa.gnt1, ifa.gnt2}, 8'b10);

        // MAX_HOLD=0: no preemption ever, done hands over.
        do_reset();
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            if (!ifb.gnt1 || ifb.preempt) bad++;
        end
        chk("t6_held", 8'(bad), 8'd0);
        chk("t6_hold_sat", 8'(ifb.hold_cnt), 8'd15);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("t6_done_g2", {5'd0, ifb.gnt2, ifb.sel, ifb.preempt}, 8'b110);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
